// File: rtl/dbg_mem_pkg.sv
// dbg_mem_pkg: FSM state encoding and default sizing for debug_mem_master.
package dbg_mem_pkg;
    localparam int DEPTH_DEF = 32;
    localparam int LEN_W_DEF = 4;
    typedef enum logic [2:0] {IDLE, RD_ACC, RD_RSP, WR_ACC, WR_RSP, ERR_RSP} state_e;
endpackage

// File: rtl/dbg_burst_ctr.sv
// dbg_burst_ctr: burst address/beat counter with load, step, wrap at DEPTH and last-beat flag.
module dbg_burst_ctr
    import dbg_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      load_addr,
    input  logic [LEN_W-1:0] load_len,
    output logic [31:0]      addr,
    output logic             last
);
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] left_q, left_d;
    always_comb begin
        addr_d = addr_q;
        left_d = left_q;
        if (load) begin
            addr_d = load_addr;
            left_d = load_len;
        end else if (step) begin
            addr_d = (addr_q >= 32'(DEPTH - 1)) ? '0 : addr_q + 32'd1;
            left_d = left_q - LEN_W'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            left_q <= '0;
        end else begin
            addr_q <= addr_d;
            left_q <= left_d;
        end
    end
    assign addr = addr_q;
    assign last = (left_q == '0);
endmodule

// File: rtl/debug_mem_master.sv
// debug_mem_master: command-driven read/write burst master for a word-addressed data memory.
// Define DBG_MEM_BOUNDS_CHECK_EN to reject out-of-range bursts with an error response.
module debug_mem_master
    import dbg_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_last,
    output logic             rsp_err,
    output logic             Mem_read,
    output logic             Mem_write,
    output logic [31:0]      mem_addr,
    output logic [31:0]      write_data,
    input  logic [31:0]      mem_out
);
`ifdef DBG_MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    state_e      state_q, state_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [31:0] cur_addr;
    logic        load, step, last, oob;

    dbg_burst_ctr #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .addr      (cur_addr),
        .last      (last)
    );

    // 33-bit sum so a start address near 2^32 cannot wrap past the check
    assign oob = BOUNDS_EN && (({1'b0, cmd_addr} >= 33'(DEPTH)) ||
                               ({1'b0, cmd_addr} + 33'(cmd_len) >= 33'(DEPTH)));

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        load       = 1'b0;
        step       = 1'b0;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        rsp_valid  = 1'b0;
        rsp_last   = 1'b0;
        rsp_err    = 1'b0;
        rsp_data   = '0;
        Mem_read   = 1'b0;
        Mem_write  = 1'b0;
        mem_addr   = '0;
        write_data = '0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load    = 1'b1;
                    state_d = oob ? ERR_RSP : (cmd_write ? WR_ACC : RD_ACC);
                end
            end
            RD_ACC: begin
                Mem_read   = 1'b1;
                mem_addr   = cur_addr;
                rsp_data_d = mem_out;
                state_d    = RD_RSP;
            end
            RD_RSP: begin
                rsp_valid = 1'b1;
                rsp_last  = last;
                rsp_data  = rsp_data_q;
                if (rsp_ready) begin
                    step    = !last;
                    state_d = last ? IDLE : RD_ACC;
                end
            end
            WR_ACC: begin
                wr_ready   = 1'b1;
                mem_addr   = cur_addr;
                Mem_write  = wr_valid;
                write_data = wr_valid ? wr_data : '0;
                if (wr_valid) begin
                    step    = !last;
                    state_d = last ? WR_RSP : WR_ACC;
                end
            end
            WR_RSP: begin
                rsp_valid = 1'b1;
                rsp_last  = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            ERR_RSP: begin
                rsp_valid = 1'b1;
                rsp_last  = 1'b1;
                rsp_err   = BOUNDS_EN;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_debug_mem_master.sv
// tb_debug_mem_master: vector table plus random bursts against a word-array reference model.
module tb_debug_mem_master;
    localparam int DEPTH = 32;
    localparam int LEN_W = 4;
    localparam int AW = $clog2(DEPTH);
`ifdef DBG_MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b1;
    logic cmd_valid = 0, cmd_write = 0, wr_valid = 0, rsp_ready = 0;
    logic [31:0] cmd_addr = 0, wr_data = 0;
    logic [LEN_W-1:0] cmd_len = 0;
    logic cmd_ready, wr_ready, rsp_valid, rsp_last, rsp_err, Mem_read, Mem_write;
    logic [31:0] rsp_data, mem_addr, write_data, mem_out;

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    int checks = 0, errors = 0, inv_bad = 0;
    int strb_a[$];
    bit strb_w[$];

    typedef struct {
        bit          wr;
        int          addr;
        int          len;
        int          hold;
        bit          gaps;
        logic [31:0] base;
        longint      exp_first;
    } vec_t;
    vec_t vecs[$];

    debug_mem_master #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .Mem_read(Mem_read), .Mem_write(Mem_write), .mem_addr(mem_addr),
        .write_data(write_data), .mem_out(mem_out)
    );

    always #5 clk = ~clk;
    assign mem_out = mem[mem_addr[AW-1:0]];

    always @(posedge clk) begin
        if (Mem_write) mem[mem_addr[AW-1:0]] <= write_data;
        if (Mem_read || Mem_write) begin
            strb_a.push_back(int'(mem_addr));
            strb_w.push_back(Mem_write);
        end
        if ((Mem_read && Mem_write) || (!Mem_write && write_data != 0)) inv_bad++;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic bit oob(input int a, input int l);
        return BOUNDS && (a >= DEPTH || a + l >= DEPTH);
    endfunction

    task automatic run_burst(input bit wr, input int addr, input int len, input int hold,
                             input bit gaps, input logic [31:0] base, input longint exp_first);
        logic [31:0] wd[$], exp_r[$], held, first_data;
        int exp_a[$];
        bit exp_l[$], err, done, busy_bad, stable_bad, holding;
        int nbeat, nrsp, cyc, first, hc;
        err = oob(addr, len);
        done = 0; busy_bad = 0; stable_bad = 0; holding = 0;
        nbeat = 0; nrsp = 0; cyc = 0; first = -1; hc = hold; held = 0; first_data = 0;
        for (int i = 0; i <= len; i++) begin
            wd.push_back(base + 32'(i));
            if (!err) exp_a.push_back((addr + i) % DEPTH);
            if (!err && !wr) begin
                exp_r.push_back(ref_mem[(addr + i) % DEPTH]);
                exp_l.push_back(i == len);
            end
        end
        if (err || wr) begin
            exp_r.push_back(32'h0);
            exp_l.push_back(1'b1);
        end
        strb_a.delete();
        strb_w.delete();
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = 32'(addr); cmd_len = LEN_W'(len);
        #1 chk("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0;
        while (!done && cyc < 300) begin
            cyc++;
            wr_valid = wr && nbeat <= len && (!gaps || $urandom_range(0, 2) != 0);
            wr_data = (nbeat <= len) ? wd[nbeat] : $urandom;
            if (!wr) begin
                wr_valid = ($urandom_range(0, 1) == 1);
                wr_data = $urandom;
            end
            rsp_ready = (hc > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            if (cmd_ready) busy_bad = 1;
            if (wr_valid && wr_ready) nbeat++;
            if (rsp_valid) begin
                if (first < 0) first = cyc;
                if (holding && rsp_data != held) stable_bad = 1;
                if (rsp_ready) begin
                    if (nrsp == 0) first_data = rsp_data;
                    if (nrsp < exp_r.size()) begin
                        chk("rsp_data", rsp_data, exp_r[nrsp]);
                        chk("rsp_last", rsp_last, exp_l[nrsp]);
                    end
                    chk("rsp_err", rsp_err, err);
                    nrsp++;
                    holding = 0;
                    if (rsp_last) done = 1;
                end else begin
                    holding = 1;
                    held = rsp_data;
                    if (hc > 0) hc--;
                end
            end
            @(negedge clk);
        end
        wr_valid = 0;
        rsp_ready = 0;
        chk("burst_done", done, 1);
        chk("rsp_count", nrsp, exp_r.size());
        chk("beats_taken", nbeat, (wr && !err) ? len + 1 : 0);
        chk("strobe_count", strb_a.size(), exp_a.size());
        for (int i = 0; i < strb_a.size() && i < exp_a.size(); i++) begin
            chk("strobe_addr", strb_a[i], exp_a[i]);
            chk("strobe_kind", strb_w[i], wr);
        end
        chk("cmd_ready_busy", busy_bad, 0);
        if (hold > 0) chk("rsp_stable", stable_bad, 0);
        if (!wr || err) chk("first_rsp_latency", first, err ? 1 : 2);
        if (exp_first >= 0) chk("first_data", first_data, exp_first[31:0]);
        if (wr && !err)
            for (int i = 0; i <= len; i++) ref_mem[(addr + i) % DEPTH] = wd[i];
        for (int i = 0; i <= len; i++)
            chk("mem_content", mem[(addr + i) % DEPTH], ref_mem[(addr + i) % DEPTH]);
    endtask

    task automatic reset_mid;
        logic [31:0] wd[4];
        int n, cyc;
        n = 0; cyc = 0;
        for (int i = 0; i < 4; i++) wd[i] = 32'h50 + 32'(i);
        strb_a.delete();
        strb_w.delete();
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 16; cmd_len = 3;
        @(negedge clk);
        cmd_valid = 0;
        while (n < 2 && cyc < 50) begin
            cyc++;
            wr_valid = 1;
            wr_data = wd[n];
            #1 if (wr_ready) n++;
            @(negedge clk);
        end
        wr_valid = 1;
        wr_data = wd[2];
        rst_n = 0;
        #1;
        chk("rst_mem_write", Mem_write, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        wr_valid = 0;
        @(negedge clk);
        #1 chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_strobes", strb_a.size(), 2);
        ref_mem[16] = wd[0];
        ref_mem[17] = wd[1];
        for (int a = 16; a < 20; a++) chk("rst_mem", mem[a], ref_mem[a]);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[12] = 32'h8;
        ref_mem[12] = 32'h8;
        #1 rst_n = 0;
        #1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_strobes", {30'b0, Mem_read, Mem_write}, 0);
        chk("reset_wr_ready", wr_ready, 0);
        chk("reset_last_err", {30'b0, rsp_last, rsp_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        vecs.push_back('{0, 12, 0, 0, 0, 32'h0, 64'sd8});
        vecs.push_back('{1, 4, 2, 0, 1, 32'hA, -1});
        vecs.push_back('{0, 4, 2, 0, 1, 32'h0, 64'sd10});
        vecs.push_back('{0, 30, 3, 0, 0, 32'h0, -1});
        vecs.push_back('{0, 8, 1, 5, 0, 32'h0, -1});
        vecs.push_back('{1, 31, 2, 1, 1, 32'h100, -1});
        vecs.push_back('{1, 30, 3, 0, 1, 32'h200, -1});
        vecs.push_back('{0, 0, 15, 2, 0, 32'h0, -1});
        if (BOUNDS) vecs.push_back('{0, 32, 0, 0, 0, 32'h0, -1});
        foreach (vecs[k])
            run_burst(vecs[k].wr, vecs[k].addr, vecs[k].len, vecs[k].hold,
                      vecs[k].gaps, vecs[k].base, vecs[k].exp_first);

        reset_mid();

        for (int k = 0; k < 25; k++)
            run_burst($urandom_range(0, 1) == 1,
                      int'($urandom_range(0, BOUNDS ? DEPTH + 2 : DEPTH - 1)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                      1'b1, $urandom, -1);

        chk("strobe_invariants", inv_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
